// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: registered ID->EX decode stage for the 5-stage MIPS pipeline.
// Turns one 32-bit MIPS instruction per accepted transfer into the ALU control
// word (op code, operand selects, extended immediate, write-back controls) and
// holds it in a single-entry output register behind a valid/ready handshake,
// with stall back-pressure and a highest-priority flush.
module alu_ctrl_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op,
  output logic        out_a_sel,
  output logic        out_b_sel,
  output logic [31:0] out_imm32,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic        out_reg_we,
  output logic        out_ovf_chk,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  // ALU operation codes; this map is shared with the EX stage and must not move.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_AND    = 4'h2,
    ALU_OR     = 4'h3,
    ALU_SRL    = 4'h4,
    ALU_SRA    = 4'h5,
    ALU_SLL    = 4'h6,
    ALU_SLT    = 4'h7,
    ALU_SLTU   = 4'h8,
    ALU_NOR    = 4'h9,
    ALU_XOR    = 4'hA,
    ALU_PASS_A = 4'hB,
    ALU_PASS_B = 4'hC
  } alu_op_e;

  // Everything the EX stage needs about one instruction.
  typedef struct packed {
    alu_op_e     alu_op;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_we;
    logic        ovf_chk;
    logic        illegal;
    logic [31:0] pc;
  } ctrl_t;

  // Instruction fields.
  logic [5:0]  opcode;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_shamt;
  logic [5:0]  f_funct;
  logic [15:0] f_imm16;

  assign opcode  = in_instr[31:26];
  assign f_rs    = in_instr[25:21];
  assign f_rt    = in_instr[20:16];
  assign f_rd    = in_instr[15:11];
  assign f_shamt = in_instr[10:6];
  assign f_funct = in_instr[5:0];
  assign f_imm16 = in_instr[15:0];

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  valid_d;
  logic  valid_q;
  logic  load;

  // Combinational decode of the incoming instruction into a control word.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    ctrl_d         = '0;
    ctrl_d.alu_op  = ALU_ADD;
    ctrl_d.imm32   = {{16{f_imm16[15]}}, f_imm16};
    ctrl_d.rs      = f_rs;
    ctrl_d.rt      = f_rt;
    ctrl_d.rd      = f_rt;
    ctrl_d.pc      = in_pc;

    case (opcode)
      6'h00: begin
        // R-type: destination is rd; imm32 carries the zero-extended shamt so
        // EX can source operand A from it on immediate shifts.
        ctrl_d.imm32  = {27'd0, f_shamt};
        ctrl_d.rd     = f_rd;
        ctrl_d.reg_we = 1'b1;
        case (f_funct)
          6'h20: begin ctrl_d.alu_op = ALU_ADD; ctrl_d.ovf_chk = 1'b1; end
          6'h21: ctrl_d.alu_op = ALU_ADD;
          6'h22: begin ctrl_d.alu_op = ALU_SUB; ctrl_d.ovf_chk = 1'b1; end
          6'h23: ctrl_d.alu_op = ALU_SUB;
          6'h24: ctrl_d.alu_op = ALU_AND;
          6'h25: ctrl_d.alu_op = ALU_OR;
          6'h26: ctrl_d.alu_op = ALU_XOR;
          6'h27: ctrl_d.alu_op = ALU_NOR;
          6'h2A: ctrl_d.alu_op = ALU_SLT;
          6'h2B: ctrl_d.alu_op = ALU_SLTU;
          6'h00: begin ctrl_d.alu_op = ALU_SLL; ctrl_d.a_sel = 1'b1; end
          6'h02: begin ctrl_d.alu_op = ALU_SRL; ctrl_d.a_sel = 1'b1; end
          6'h03: begin ctrl_d.alu_op = ALU_SRA; ctrl_d.a_sel = 1'b1; end
          6'h04: ctrl_d.alu_op = ALU_SLL;
          6'h06: ctrl_d.alu_op = ALU_SRL;
          6'h07: ctrl_d.alu_op = ALU_SRA;
          6'h08: begin ctrl_d.alu_op = ALU_PASS_A; ctrl_d.reg_we = 1'b0; end
          default: begin ctrl_d.illegal = 1'b1; ctrl_d.reg_we = 1'b0; end
        endcase
      end
      6'h08: begin
        ctrl_d.alu_op = ALU_ADD; ctrl_d.b_sel = 1'b1;
        ctrl_d.reg_we = 1'b1;    ctrl_d.ovf_chk = 1'b1;
      end
      6'h09: begin ctrl_d.alu_op = ALU_ADD;  ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1; end
      6'h0A: begin ctrl_d.alu_op = ALU_SLT;  ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1; end
      6'h0B: begin ctrl_d.alu_op = ALU_SLTU; ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1; end
      6'h0C: begin
        ctrl_d.alu_op = ALU_AND; ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1;
        ctrl_d.imm32  = {16'h0000, f_imm16};
      end
      6'h0D: begin
        ctrl_d.alu_op = ALU_OR;  ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1;
        ctrl_d.imm32  = {16'h0000, f_imm16};
      end
      6'h0E: begin
        ctrl_d.alu_op = ALU_XOR; ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1;
        ctrl_d.imm32  = {16'h0000, f_imm16};
      end
      6'h0F: begin
        ctrl_d.alu_op = ALU_PASS_B; ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1;
        ctrl_d.imm32  = {f_imm16, 16'h0000};
      end
      6'h23: begin ctrl_d.alu_op = ALU_ADD; ctrl_d.b_sel = 1'b1; ctrl_d.reg_we = 1'b1; end
      6'h2B: begin ctrl_d.alu_op = ALU_ADD; ctrl_d.b_sel = 1'b1; end
      // Branch compare: rs - rt, result only feeds the zero flag.
      6'h04, 6'h05: ctrl_d.alu_op = ALU_SUB;
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  // Handshake: accept when the holding register is empty or draining this cycle.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Output-valid next state: flush wins, then a new transfer, then a drain.
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // Output register: valid bit plus the held control word.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= only so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      valid_q   <= 1'b0;
      // NOTE: the payload is reset too (not just valid) so EX sees a defined
      // word and out_pc shows RESET_PC straight out of reset.
      ctrl_q    <= '0;
      ctrl_q.pc <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      if (load) ctrl_q <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_op  = ctrl_q.alu_op;
  assign out_a_sel   = ctrl_q.a_sel;
  assign out_b_sel   = ctrl_q.b_sel;
  assign out_imm32   = ctrl_q.imm32;
  assign out_rs      = ctrl_q.rs;
  assign out_rt      = ctrl_q.rt;
  assign out_rd      = ctrl_q.rd;
  assign out_reg_we  = ctrl_q.reg_we;
  assign out_ovf_chk = ctrl_q.ovf_chk;
  assign out_illegal = ctrl_q.illegal;
  assign out_pc      = ctrl_q.pc;

endmodule

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Registered decode stage that produces the control word consumed by the ALU: 4-bit operation code, operand-A/B source selects, extended immediate, and write-back controls.
- Sits between the ID stage instruction register and the EX stage in the 5-stage MIPS pipeline.
- Decodes one 32-bit MIPS instruction per accepted transfer into a single-entry output register with a valid/ready handshake, stall back-pressure and flush.

Parameters:
- RESET_PC, 32'h0000_3000, value driven on out_pc at reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction on in_instr/in_pc is valid
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  32  MIPS instruction word
- in_pc  input  32  PC of in_instr
- flush  input  1  squash the held entry (branch/exception redirect)
- out_valid  output  1  control word registered and presented to EX
- out_ready  input  1  EX accepts the word this cycle
- out_alu_op  output  4  ALU operation code
- out_a_sel  output  1  0: A = GPR[rs]; 1: A = zero-extended shamt
- out_b_sel  output  1  0: B = GPR[rt]; 1: B = out_imm32
- out_imm32  output  32  extended immediate
- out_rs, out_rt, out_rd  output  5 each  register indices; out_rd is the write destination (rd for R-type, rt for I-type)
- out_reg_we  output  1  result written to GPR
- out_ovf_chk  output  1  signed-overflow trap enabled (add/sub/addi)
- out_illegal  output  1  reserved/unsupported instruction
- out_pc  output  32  PC of the held instruction

Behaviour:
- ALU code map (fixed, shared with EX): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SRL (B>>A[4:0]), 5 SRA, 6 SLL, 7 SLT signed, 8 SLTU, 9 NOR, A XOR, B pass A, C pass B.
- Shifts: shift amount always comes from operand A and the shifted value from B.
  - sll/srl/sra: a_sel=1, b_sel=0.
  - sllv/srlv/srav: a_sel=0, b_sel=0.
- R-type decode (op=0), by funct:
  - 20 add: ADD, ovf_chk=1
  - 21 addu: ADD
  - 22 sub: SUB, ovf_chk=1
  - 23 subu: SUB
  - 24 and: AND; 25 or: OR; 26 xor: XOR; 27 nor: NOR
  - 2A slt: SLT; 2B sltu: SLTU
  - 00 sll: SLL; 02 srl: SRL; 03 sra: SRA
  - 04 sllv: SLL; 06 srlv: SRL; 07 srav: SRA
  - 08 jr: pass A, reg_we=0
  - reg_we=1 for all R-type except jr.
- I-type decode (b_sel=1), by opcode:
  - 08 addi: ADD, sign-extended imm, ovf_chk=1
  - 09 addiu: ADD, sign-extended imm
  - 0A slti: SLT, sign-extended imm
  - 0B sltiu: SLTU, sign-extended imm
  - 0C andi: AND, zero-extended imm
  - 0D ori: OR, zero-extended imm
  - 0E xori: XOR, zero-extended imm
  - 0F lui: pass B, imm32 = {imm16, 16'h0}
  - 23 lw: ADD, sign-extended imm, reg_we=1
  - 2B sw: ADD, sign-extended imm, reg_we=0
  - 04 beq / 05 bne: SUB, b_sel=0, reg_we=0
- Any other opcode/funct: illegal=1, reg_we=0, ovf_chk=0, alu_op=ADD, b_sel=0.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Transfer in when in_valid & in_ready; the decoded word registers on that edge. Latency is 1 cycle.
  - Without a new transfer in, out_valid clears on out_ready.
  - While out_valid & !out_ready, all out_* hold stable.
- Flush: highest priority.
  - On a flush edge, out_valid becomes 0 and in_valid in that cycle is ignored.
  - in_ready is still computed as above; the dropped instruction counts as squashed.
- Simultaneous out_ready and in_valid: back-to-back; the new word replaces the old with out_valid staying 1, giving 1 instruction/cycle throughput.
- Reset (asynchronous, any time including mid-stall):
  - out_valid=0, out_alu_op=0, a_sel=b_sel=0, imm32=0, rs/rt/rd=0, reg_we=0, ovf_chk=0, illegal=0, out_pc=RESET_PC.
  - After rst_n rises, in_ready=1 in the first cycle.
- Payload outputs are only meaningful while out_valid=1. When invalid they hold their last value; they are not cleared.

Test Plan:
- addiu $t0,$t1,-4 (0x2528FFFC), out_ready=1 -> next cycle: out_valid=1, alu_op=0, b_sel=1, imm32=0xFFFFFFFC, rs=9, rd=8, reg_we=1, ovf_chk=0.
- sra $v0,$t1,3 (0x000910C3) -> alu_op=5, a_sel=1, b_sel=0, rt=9, rd=2, reg_we=1; then lui $at,0x1234 (0x3C011234) -> alu_op=C, imm32=0x12340000, rd=1.
- ori $t0,$t0,0xFFFF (0x3508FFFF) held with out_ready=0 for 3 cycles -> in_ready=0, outputs stable with imm32=0x0000FFFF, alu_op=3. Raise out_ready with a new in_valid -> back-to-back replace, out_valid stays 1.
- Illegal word 0xFC000000 -> illegal=1, reg_we=0, out_valid=1.
- Flush in the same cycle as in_valid of 0x2528FFFC -> out_valid=0 next cycle.
- Assert rst_n=0 mid-stall -> all outputs immediately at reset values, out_pc=0x00003000.
